// File: rtl/demux_rr_sched.sv
// ============================================================================
// demux_rr_sched : round-robin burst scheduler driving an 8-way demux S/EN.
// Optional: define DEMUX_RR_SCHED_PRIO0_EN for channel-0 priority/preemption.
// Revision: 1.0
// ============================================================================
`default_nettype none

module demux_rr_sched #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] req,
  output logic [2:0] s,
  output logic       en,
  output logic [7:0] gnt,
  output logic       busy
);

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic [2:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0] w_rr_win;
  logic       w_rr_found;
  logic [2:0] w_win;
  logic       w_upd_ptr;
  logic       w_preempt;
  logic       w_req_any;

  assign w_req_any = |req;

  // Search starts one past the last winner so every requester is reached.
  always_comb begin
    logic [2:0] idx;
    w_rr_win   = r_ptr;
    w_rr_found = 1'b0;
    idx        = r_ptr;
    for (int i = 1; i <= 8; i++) begin
      idx = r_ptr + 3'(i);
      if (!w_rr_found && req[idx]) begin
        w_rr_win   = idx;
        w_rr_found = 1'b1;
      end
    end
  end

`ifdef DEMUX_RR_SCHED_PRIO0_EN
  // Channel 0 bypasses the rotation and leaves the pointer untouched.
  assign w_win     = req[0] ? 3'd0 : w_rr_win;
  assign w_upd_ptr = !req[0];
  assign w_preempt = req[0] && (s != 3'd0);
`else
  assign w_win     = w_rr_win;
  assign w_upd_ptr = 1'b1;
  assign w_preempt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 3'd7;
      r_cnt   <= '0;
      s       <= 3'd0;
      en      <= 1'b0;
      gnt     <= 8'd0;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, GAP: begin
          if (enable && w_req_any) begin
            r_state <= GRANT;
            r_cnt   <= CNT_W'(1);
            s       <= w_win;
            en      <= 1'b1;
            gnt     <= 8'(1) << w_win;
            busy    <= 1'b1;
            if (w_upd_ptr) r_ptr <= w_win;
          end else begin
            r_state <= IDLE;
            r_cnt   <= '0;
            en      <= 1'b0;
            gnt     <= 8'd0;
            busy    <= 1'b0;
          end
        end
        GRANT: begin
          if (!enable) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            en      <= 1'b0;
            gnt     <= 8'd0;
            busy    <= 1'b0;
          end else if (!req[s] || (r_cnt == BURST_MAX) || w_preempt) begin
            r_state <= GAP;
            r_cnt   <= '0;
            en      <= 1'b0;
            gnt     <= 8'd0;
            busy    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          en      <= 1'b0;
          gnt     <= 8'd0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
